// File: rtl/song_recorder.sv
// song_recorder: records debounced key presses into a song note memory.
// Ports: clk, rst (async, active-high), rec_en, note_in, wr_ready ->
// wr_en/wr_addr/wr_data (one write at a time), recording, full, done.
// Address 0 receives the note count; notes go to 1..N.
// Optional macro SONG_RECORDER_REST_EN: silent gaps record one 0 (rest) word.
module song_recorder #(
  parameter int DATA_W          = 10,
  parameter int ADDR_W          = 7,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REST_CYCLES     = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_en,
  input  logic [DATA_W-1:0] note_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              recording,
  output logic              full,
  output logic              done
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef SONG_RECORDER_REST_EN
  localparam int ZLIM = (REST_CYCLES > DEBOUNCE_CYCLES) ?
                        REST_CYCLES : DEBOUNCE_CYCLES;
`else
  localparam int ZLIM = DEBOUNCE_CYCLES;
`endif
  localparam int ZW = $clog2(ZLIM + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LISTEN, S_DEB, S_WNOTE, S_WLEN, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic              r_rec;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_last;
  logic [DATA_W-1:0] r_cand;
  logic [DBW-1:0]    r_deb;
  logic [ZW-1:0]     r_zcnt;
  logic              r_stop;
  logic              r_full;
  logic              r_done;

  logic              w_rise;
  logic              w_fall;
  logic              w_zero;
  logic              w_new;
  logic              w_clr_last;
  logic              w_deb_end;
  logic              w_rest;
  logic [ADDR_W-1:0] w_cnt_nx;
  logic              w_full_nx;

  assign w_rise     = rec_en & ~r_rec;
  assign w_fall     = ~rec_en & r_rec;
  assign w_zero     = (note_in == '0);
  assign w_new      = !w_zero && (note_in != r_last);
  // zero-run counter is the number of prior consecutive silent cycles
  assign w_clr_last = w_zero && (r_zcnt >= ZW'(DEBOUNCE_CYCLES - 1));
  assign w_deb_end  = (r_deb == DBW'(DEBOUNCE_CYCLES - 1));
  assign w_cnt_nx   = r_count + ADDR_W'(1);
  assign w_full_nx  = &w_cnt_nx;

`ifdef SONG_RECORDER_REST_EN
  logic r_rest_wr;

  assign w_rest = w_zero && (r_zcnt >= ZW'(REST_CYCLES - 1)) &&
                  (r_count != '0) && !r_rest_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rest_wr <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && w_rise) begin
      r_rest_wr <= 1'b0;
    end else if (r_state == S_WNOTE && wr_ready) begin
      r_rest_wr <= (r_cand == '0);
    end
  end
`else
  logic w_unused_rest;
  assign w_unused_rest = (REST_CYCLES != 0);
  assign w_rest = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:   if (w_rise) w_state_nx = S_LISTEN;
      S_LISTEN: begin
        if (w_fall)      w_state_nx = S_WLEN;
        else if (w_new)  w_state_nx = S_DEB;
        else if (w_rest) w_state_nx = S_WNOTE;
      end
      S_DEB: begin
        if (w_fall)                 w_state_nx = S_WLEN;
        else if (note_in != r_cand) w_state_nx = S_LISTEN;
        else if (w_deb_end)         w_state_nx = S_WNOTE;
      end
      S_WNOTE: begin
        if (wr_ready) begin
          if (w_full_nx || r_stop || w_fall) w_state_nx = S_WLEN;
          else                               w_state_nx = S_LISTEN;
        end
      end
      S_WLEN:   if (wr_ready) w_state_nx = S_DONE;
      S_DONE:   if (w_rise) w_state_nx = S_LISTEN;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rec   <= 1'b0;
      r_count <= '0;
      r_last  <= '0;
      r_cand  <= '0;
      r_deb   <= '0;
      r_zcnt  <= '0;
      r_stop  <= 1'b0;
      r_full  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rec <= rec_en;
      if (!w_zero)
        r_zcnt <= '0;
      else if (r_zcnt != ZW'(ZLIM))
        r_zcnt <= r_zcnt + ZW'(1);
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_rise) begin
            r_count <= '0;
            r_last  <= '0;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
            r_stop  <= 1'b0;
          end
        end
        S_LISTEN: begin
          if (w_clr_last) r_last <= '0;
          if (!w_fall) begin
            if (w_new) begin
              r_cand <= note_in;
              r_deb  <= '0;
            end else if (w_rest) begin
              r_cand <= '0;
            end
          end
        end
        S_DEB: if (!w_deb_end) r_deb <= r_deb + DBW'(1);
        S_WNOTE: begin
          if (w_fall) r_stop <= 1'b1;
          if (wr_ready) begin
            r_count <= w_cnt_nx;
            r_last  <= r_cand;
            if (w_full_nx) r_full <= 1'b1;
          end
        end
        S_WLEN: if (wr_ready) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    recording = 1'b0;
    unique case (r_state)
      S_LISTEN, S_DEB: recording = 1'b1;
      S_WNOTE: begin
        recording = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = w_cnt_nx;
        wr_data   = r_cand;
      end
      S_WLEN: begin
        wr_en   = 1'b1;
        wr_data = DATA_W'(r_count);
      end
      default: ;
    endcase
  end

  assign full = r_full;
  assign done = r_done;

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: scoreboard bench for song_recorder.
// Expected writes are queued by stimulus; a negedge monitor checks them.
module tb_song_recorder;

  localparam int DW = 10;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rec_en;
  logic [DW-1:0] note_in;
  logic          wr_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          recording;
  logic          full;
  logic          done;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } st_t;

  wr_t exp_q[$];
  st_t st_q[$];
  int  errors = 0;
  int  checks = 0;
  int  stalls = 0;

  always #5 clk = ~clk;

  song_recorder #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEBOUNCE_CYCLES(4),
    .REST_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rec_en(rec_en),
    .note_in(note_in),
    .wr_ready(wr_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .recording(recording),
    .full(full),
    .done(done)
  );

  task automatic cmp(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // monitor: drains status samples and checks every presented write
  always @(negedge clk) begin
    st_t s;
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      cmp(s.name, s.act, s.exp);
    end
    if (!rst && wr_en) begin
      if (!wr_ready) stalls++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected none",
                 wr_addr, wr_data);
      end else begin
        cmp("wr_addr", int'(wr_addr), int'(exp_q[0].a));
        cmp("wr_data", int'(wr_data), int'(exp_q[0].d));
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(string n, int a, int e);
    st_q.push_back('{name: n, act: a, exp: e});
  endtask

  task automatic expect_wr(int a, int d);
    exp_q.push_back('{a: AW'(a), d: DW'(d)});
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(string n);
    int k = 0;
    while (!done && k < 200) begin
      cyc(1);
      k++;
    end
    chk(n, int'(done), 1);
  endtask

  task automatic wait_wr(string n);
    int k = 0;
    while (!wr_en && k < 50) begin
      cyc(1);
      k++;
    end
    chk(n, int'(wr_en), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    rst = 1'b1;
    rec_en = 1'b0;
    note_in = '0;
    wr_ready = 1'b1;
    cyc(2);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_recording", int'(recording), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    cyc(2);

    // single note
    expect_wr(1, 'h123);
    expect_wr(0, 1);
    rec_en = 1'b1;
    note_in = 'h123;
    cyc(10);
    chk("s1_recording", int'(recording), 1);
    rec_en = 1'b0;
    note_in = '0;
    wait_done("s1_done");
    chk("s1_rec_off", int'(recording), 0);
    chk("s1_full", int'(full), 0);
    chk("s1_drain", exp_q.size(), 0);

    // bounce, hold, release and re-press
    expect_wr(1, 'h045);
    expect_wr(2, 'h045);
    expect_wr(0, 2);
    rec_en = 1'b1;
    cyc(2);
    chk("s2_done_clr", int'(done), 0);
    note_in = 'h045;
    cyc(2);
    note_in = '0;
    cyc(1);
    note_in = 'h045;
    cyc(30);
    chk("s2_one_write", exp_q.size(), 2);
    note_in = '0;
    cyc(6);
    note_in = 'h045;
    cyc(10);
    note_in = '0;
    rec_en = 1'b0;
    wait_done("s2_done");
    chk("s2_drain", exp_q.size(), 0);

    // backpressure with stop during the stalled note write
    expect_wr(1, 'h2AB);
    expect_wr(0, 1);
    wr_ready = 1'b0;
    rec_en = 1'b1;
    note_in = 'h2AB;
    cyc(2);
    wait_wr("s3_wr_seen");
    s0 = stalls;
    cyc(2);
    rec_en = 1'b0;
    cyc(3);
    chk("s3_stalled", stalls - s0, 5);
    chk("s3_recording", int'(recording), 1);
    wr_ready = 1'b1;
    note_in = '0;
    wait_done("s3_done");
    chk("s3_drain", exp_q.size(), 0);

    // fill to capacity; eighth note is ignored
    for (int i = 1; i <= 7; i++) expect_wr(i, 'h100 + 3 * i);
    expect_wr(0, 7);
    rec_en = 1'b1;
    cyc(2);
    for (int i = 1; i <= 8; i++) begin
      note_in = DW'('h100 + 3 * i);
      cyc(8);
      note_in = '0;
      cyc(2);
    end
    chk("s4_full", int'(full), 1);
    chk("s4_done", int'(done), 1);
    chk("s4_rec_off", int'(recording), 0);
    cyc(5);
    chk("s4_no_restart", int'(done), 1);
    chk("s4_drain", exp_q.size(), 0);

    // reset in the middle of a debounce
    rec_en = 1'b0;
    cyc(2);
    rec_en = 1'b1;
    note_in = 'h077;
    cyc(4);
    chk("s5_recording", int'(recording), 1);
    rst = 1'b1;
    #1;
    chk("s5_rst_wr_en", int'(wr_en), 0);
    chk("s5_rst_rec", int'(recording), 0);
    chk("s5_rst_full", int'(full), 0);
    chk("s5_rst_done", int'(done), 0);
    rec_en = 1'b0;
    note_in = '0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    expect_wr(1, 'h099);
    expect_wr(0, 1);
    rec_en = 1'b1;
    note_in = 'h099;
    cyc(10);
    note_in = '0;
    rec_en = 1'b0;
    wait_done("s5_done");
    chk("s5_drain", exp_q.size(), 0);

    // long silence between two notes
    expect_wr(1, 'h010);
`ifdef SONG_RECORDER_REST_EN
    expect_wr(2, 0);
    expect_wr(3, 'h020);
    expect_wr(0, 3);
`else
    expect_wr(2, 'h020);
    expect_wr(0, 2);
`endif
    rec_en = 1'b1;
    cyc(2);
    note_in = 'h010;
    cyc(8);
    note_in = '0;
    cyc(25);
    note_in = 'h020;
    cyc(8);
    note_in = '0;
    rec_en = 1'b0;
    wait_done("s6_done");

    cyc(5);
    chk("final_drain", exp_q.size(), 0);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
